// File: rtl/dm_pkg.sv
// Shared encodings for the data-memory access unit: access types, error causes,
// FSM states and the per-access-type size/sign/legality helpers.
package dm_pkg;

  typedef enum logic [2:0] {
    dm_word          = 3'b000,
    dm_half          = 3'b001,
    dm_half_unsigned = 3'b010,
    dm_byte          = 3'b011,
    dm_byte_unsigned = 3'b100,
    dm_dword         = 3'b101,
    dm_word_unsigned = 3'b110
  } dm_ctrl_e;

  localparam logic [1:0] cause_none     = 2'b00;
  localparam logic [1:0] cause_misalign = 2'b01;
  localparam logic [1:0] cause_bad_ctrl = 2'b10;

  typedef enum logic [2:0] {
    st_idle  = 3'd0,
    st_beat0 = 3'd1,
    st_beat1 = 3'd2,
    st_capt  = 3'd3,
    st_resp  = 3'd4
  } dm_state_e;

  // Access size in bytes; 0 for encodings that have no size.
  function automatic logic [3:0] ctrl_size(input logic [2:0] ctrl);
    case (ctrl)
      dm_word, dm_word_unsigned:       ctrl_size = 4'd4;
      dm_half, dm_half_unsigned:       ctrl_size = 4'd2;
      dm_byte, dm_byte_unsigned:       ctrl_size = 4'd1;
      dm_dword:                        ctrl_size = 4'd8;
      default:                         ctrl_size = 4'd0;
    endcase
  endfunction

  function automatic logic ctrl_signed(input logic [2:0] ctrl);
    ctrl_signed = (ctrl == dm_word) || (ctrl == dm_half) ||
                  (ctrl == dm_byte) || (ctrl == dm_dword);
  endfunction

  // Doubleword and unsigned-word only exist on a 64-bit memory.
  function automatic logic ctrl_legal(input logic [2:0] ctrl, input logic wide);
    case (ctrl)
      dm_word, dm_half, dm_half_unsigned, dm_byte, dm_byte_unsigned: ctrl_legal = 1'b1;
      dm_dword, dm_word_unsigned:                                    ctrl_legal = wide;
      default:                                                       ctrl_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Lane steering between right-aligned pipeline data and the memory word lanes:
// store shift/strobe generation over two beats and load extract/extend.
module dm_lane_align #(
  parameter int DATA_W = 32
) (
  input  logic [$clog2(DATA_W/8)-1:0] lane,
  input  logic [3:0]                  size,
  input  logic                        sign_ext,
  input  logic [DATA_W-1:0]           st_data,
  output logic [2*DATA_W-1:0]         st_wdata,
  output logic [2*(DATA_W/8)-1:0]     st_strb,
  input  logic [DATA_W-1:0]           ld_beat0,
  input  logic [DATA_W-1:0]           ld_beat1,
  output logic [DATA_W-1:0]           ld_data
);

  localparam int NB = DATA_W / 8;

  logic [2*NB-1:0]   size_mask;
  logic [DATA_W-1:0] ld_shifted;
  logic              ld_sign;

  generate
    for (genvar gi = 0; gi < 2 * NB; gi++) begin : g_mask
      assign size_mask[gi] = (5'(gi) < {1'b0, size});
    end
  endgenerate

  // Double-width shifts: the upper half is what a second beat carries.
  assign st_strb    = size_mask << lane;
  assign st_wdata   = {{DATA_W{1'b0}}, st_data} << {lane, 3'b000};
  assign ld_shifted = DATA_W'({ld_beat1, ld_beat0} >> {lane, 3'b000});

  always_comb begin
    ld_sign = 1'b0;
    case (size)
      4'd1:    ld_sign = ld_shifted[7];
      4'd2:    ld_sign = ld_shifted[15];
      4'd4:    ld_sign = ld_shifted[31];
      default: ld_sign = ld_shifted[DATA_W-1];
    endcase
    ld_sign = ld_sign & sign_ext;
  end

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_ext
      assign ld_data[8*gi +: 8] = (4'(gi) < size) ? ld_shifted[8*gi +: 8] : {8{ld_sign}};
    end
  endgenerate

endmodule

// File: rtl/dm_access_unit.sv
// Multi-cycle data-memory access unit: latches one request, runs one or two
// memory beats against a synchronous-read RAM and returns a registered response.
module dm_access_unit
  import dm_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [2:0]          req_ctrl,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic [1:0]          resp_cause,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int NB = DATA_W / 8;
  localparam int LW = $clog2(NB);

  dm_state_e         state_reg;
  logic              we_reg;
  logic [2:0]        ctrl_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              split_reg;
  logic [DATA_W-1:0] beat0_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              err_reg;
  logic [1:0]        cause_reg;

  logic [3:0]        in_size;
  logic [4:0]        in_span;
  logic              in_split;
  logic              in_legal;

  logic [2*DATA_W-1:0] st_wdata;
  logic [2*NB-1:0]     st_strb;
  logic [DATA_W-1:0]   ld_beat0;
  logic [DATA_W-1:0]   ld_beat1;
  logic [DATA_W-1:0]   ld_data;
  logic [ADDR_W-1:0]   base_addr;

  assign in_size  = ctrl_size(req_ctrl);
  assign in_span  = 5'(req_addr[LW-1:0]) + 5'(in_size);
  assign in_split = (in_span > 5'(NB));
  assign in_legal = ctrl_legal(req_ctrl, DATA_W == 64);

  // A non-split load captures its only beat in CAPT, so that beat is beat 0.
  assign ld_beat0 = split_reg ? beat0_reg : mem_rdata;
  assign ld_beat1 = split_reg ? mem_rdata : '0;

  dm_lane_align #(.DATA_W(DATA_W)) u_align (
    .lane     (addr_reg[LW-1:0]),
    .size     (ctrl_size(ctrl_reg)),
    .sign_ext (ctrl_signed(ctrl_reg)),
    .st_data  (wdata_reg),
    .st_wdata (st_wdata),
    .st_strb  (st_strb),
    .ld_beat0 (ld_beat0),
    .ld_beat1 (ld_beat1),
    .ld_data  (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= st_idle;
      we_reg    <= 1'b0;
      ctrl_reg  <= 3'b000;
      addr_reg  <= '0;
      wdata_reg <= '0;
      split_reg <= 1'b0;
      beat0_reg <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
      cause_reg <= cause_none;
    end else begin
      case (state_reg)
        st_idle: begin
          if (req_valid) begin
            we_reg    <= req_we;
            ctrl_reg  <= req_ctrl;
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
            split_reg <= in_split;
            rdata_reg <= '0;
            if (!in_legal) begin
              err_reg   <= 1'b1;
              cause_reg <= cause_bad_ctrl;
              state_reg <= st_resp;
            end else if (in_split && !SPLIT_EN) begin
              err_reg   <= 1'b1;
              cause_reg <= cause_misalign;
              state_reg <= st_resp;
            end else begin
              err_reg   <= 1'b0;
              cause_reg <= cause_none;
              state_reg <= st_beat0;
            end
          end
        end
        st_beat0: begin
          if (split_reg)   state_reg <= st_beat1;
          else if (we_reg) state_reg <= st_resp;
          else             state_reg <= st_capt;
        end
        st_beat1: begin
          if (we_reg) begin
            state_reg <= st_resp;
          end else begin
            beat0_reg <= mem_rdata;
            state_reg <= st_capt;
          end
        end
        st_capt: begin
          rdata_reg <= ld_data;
          state_reg <= st_resp;
        end
        st_resp: begin
          // Response fields only mean something alongside resp_valid.
          rdata_reg <= '0;
          err_reg   <= 1'b0;
          cause_reg <= cause_none;
          state_reg <= st_idle;
        end
        default: state_reg <= st_idle;
      endcase
    end
  end

  assign base_addr  = {addr_reg[ADDR_W-1:LW], {LW{1'b0}}};
  assign req_ready  = (state_reg == st_idle);
  assign resp_valid = (state_reg == st_resp);
  assign resp_rdata = rdata_reg;
  assign resp_err   = err_reg;
  assign resp_cause = cause_reg;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_reg)
      st_beat0: begin
        mem_en    = 1'b1;
        mem_addr  = base_addr;
        mem_we    = we_reg ? st_strb[NB-1:0] : '0;
        mem_wdata = st_wdata[DATA_W-1:0];
      end
      st_beat1: begin
        mem_en    = 1'b1;
        mem_addr  = base_addr + ADDR_W'(NB);
        mem_we    = we_reg ? st_strb[2*NB-1:NB] : '0;
        mem_wdata = st_wdata[2*DATA_W-1:DATA_W];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dm_access_unit.sv
// Scoreboard bench: stimulus queues expected beats/responses, a negedge monitor
// pops and compares them; two side instances cover SPLIT_EN=0 and DATA_W=64.
module tb_dm_access_unit;
  import dm_pkg::*;

  typedef struct { logic [31:0] rdata; logic err; logic [1:0] cause; int lat; int acc; } resp_t;
  typedef struct { logic [31:0] addr; logic [3:0] we; logic [31:0] wdata; } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;
  logic mem_init = 1'b1;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  resp_t resp_q[$];
  beat_t beat_q[$];
  resp_t mon_r;
  beat_t mon_b;

  // main instance: DATA_W=32, SPLIT_EN=1
  logic        req_valid = 0, req_we = 0, req_ready, resp_valid, resp_err, mem_en;
  logic [31:0] req_addr = 0, req_wdata = 0, resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  req_ctrl = 0;
  logic [1:0]  resp_cause;
  logic [3:0]  mem_we;

  dm_access_unit #(.DATA_W(32), .ADDR_W(32), .SPLIT_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ctrl(req_ctrl), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .resp_cause(resp_cause), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  // SPLIT_EN=0 instance
  logic        ns_req_valid = 0, ns_req_we = 0, ns_req_ready, ns_resp_valid, ns_resp_err, ns_mem_en;
  logic [31:0] ns_req_addr = 0, ns_req_wdata = 0, ns_resp_rdata, ns_mem_addr, ns_mem_wdata;
  logic [31:0] ns_mem_rdata = 32'h0;
  logic [2:0]  ns_req_ctrl = 0;
  logic [1:0]  ns_resp_cause;
  logic [3:0]  ns_mem_we;
  bit          ns_en_seen = 0;

  dm_access_unit #(.DATA_W(32), .ADDR_W(32), .SPLIT_EN(1'b0)) u_ns (
    .clk(clk), .rst(rst), .req_valid(ns_req_valid), .req_ready(ns_req_ready), .req_we(ns_req_we),
    .req_addr(ns_req_addr), .req_wdata(ns_req_wdata), .req_ctrl(ns_req_ctrl),
    .resp_valid(ns_resp_valid), .resp_rdata(ns_resp_rdata), .resp_err(ns_resp_err),
    .resp_cause(ns_resp_cause), .mem_en(ns_mem_en), .mem_we(ns_mem_we), .mem_addr(ns_mem_addr),
    .mem_wdata(ns_mem_wdata), .mem_rdata(ns_mem_rdata));

  // DATA_W=64 instance, constant read data
  logic        w_req_valid = 0, w_req_we = 0, w_req_ready, w_resp_valid, w_resp_err, w_mem_en;
  logic [31:0] w_req_addr = 0, w_mem_addr;
  logic [63:0] w_req_wdata = 0, w_resp_rdata, w_mem_wdata;
  logic [63:0] w_mem_rdata = 64'h0123456789ABCDEF;
  logic [2:0]  w_req_ctrl = 0;
  logic [1:0]  w_resp_cause;
  logic [7:0]  w_mem_we;

  dm_access_unit #(.DATA_W(64), .ADDR_W(32), .SPLIT_EN(1'b1)) u_w (
    .clk(clk), .rst(rst), .req_valid(w_req_valid), .req_ready(w_req_ready), .req_we(w_req_we),
    .req_addr(w_req_addr), .req_wdata(w_req_wdata), .req_ctrl(w_req_ctrl),
    .resp_valid(w_resp_valid), .resp_rdata(w_resp_rdata), .resp_err(w_resp_err),
    .resp_cause(w_resp_cause), .mem_en(w_mem_en), .mem_we(w_mem_we), .mem_addr(w_mem_addr),
    .mem_wdata(w_mem_wdata), .mem_rdata(w_mem_rdata));

  // block RAM model for the main instance
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[64] <= 32'h8899AABB;
    end else if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= mem[mem_addr[9:2]];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] bmask(input logic [3:0] we);
    for (int b = 0; b < 4; b++) bmask[8*b +: 8] = {8{we[b]}};
  endfunction

  always @(negedge clk) begin
    if (ns_mem_en) ns_en_seen = 1'b1;
    if (resp_valid) begin
      if (resp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_resp: got rdata=%h err=%b expected no response", resp_rdata, resp_err);
      end else begin
        mon_r = resp_q.pop_front();
        $display("resp: rdata=%h err=%b cause=%b lat=%0d", resp_rdata, resp_err, resp_cause, cyc - mon_r.acc + 1);
        chk("resp_rdata", 64'(resp_rdata), 64'(mon_r.rdata));
        chk("resp_err", 64'(resp_err), 64'(mon_r.err));
        chk("resp_cause", 64'(resp_cause), 64'(mon_r.cause));
        chk("latency", 64'(cyc - mon_r.acc + 1), 64'(mon_r.lat));
      end
    end
    if (mem_en) begin
      if (beat_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_beat: got addr=%h we=%b expected no beat", mem_addr, mem_we);
      end else begin
        mon_b = beat_q.pop_front();
        chk("mem_addr", 64'(mem_addr), 64'(mon_b.addr));
        chk("mem_we", 64'(mem_we), 64'(mon_b.we));
        chk("mem_wdata", 64'(mem_wdata & bmask(mon_b.we)), 64'(mon_b.wdata & bmask(mon_b.we)));
      end
    end
  end

  task automatic pb(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wdata);
    beat_t b;
    b.addr = addr; b.we = we; b.wdata = wdata;
    beat_q.push_back(b);
  endtask

  task automatic issue(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err,
                       input logic [1:0] exp_cause, input int exp_lat, input bit expect_resp);
    int n = 0;
    resp_t r;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin chk("req_ready_wait", 64'(req_ready), 64'd1); return; end
    req_valid = 1'b1; req_we = we; req_ctrl = ctrl; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (expect_resp) begin
      r.rdata = exp_rdata; r.err = exp_err; r.cause = exp_cause; r.lat = exp_lat; r.acc = cyc;
      resp_q.push_back(r);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (resp_q.size() != 0 || !req_ready); i++) @(negedge clk);
    chk("drain_resp_q", 64'(resp_q.size()), 64'd0);
    chk("drain_beat_q", 64'(beat_q.size()), 64'd0);
  endtask

  task automatic ns_run(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                        output logic err, output logic [1:0] cause, output int lat);
    int acc;
    err = 1'b0; cause = 2'b00; lat = -1;
    @(negedge clk);
    ns_req_valid = 1'b1; ns_req_we = we; ns_req_ctrl = ctrl; ns_req_addr = addr; ns_req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    acc = cyc; ns_req_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ns_resp_valid) begin err = ns_resp_err; cause = ns_resp_cause; lat = cyc - acc + 1; break; end
    end
    $display("ns resp: addr=%h err=%b cause=%b lat=%0d", addr, err, cause, lat);
  endtask

  task automatic w_run(input logic [2:0] ctrl, input logic [31:0] addr, output logic [63:0] rdata,
                       output int lat, output int nb, output logic [31:0] a0, output logic [31:0] a1);
    int acc;
    rdata = '0; lat = -1; nb = 0; a0 = '0; a1 = '0;
    @(negedge clk);
    w_req_valid = 1'b1; w_req_we = 1'b0; w_req_ctrl = ctrl; w_req_addr = addr;
    @(posedge clk); #1;
    acc = cyc; w_req_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (w_mem_en) begin
        if (nb == 0) a0 = w_mem_addr; else a1 = w_mem_addr;
        nb++;
      end
      if (w_resp_valid) begin rdata = w_resp_rdata; lat = cyc - acc + 1; break; end
    end
    $display("w resp: addr=%h rdata=%h lat=%0d beats=%0d", addr, rdata, lat, nb);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       e_err;
    logic [1:0] e_cause;
    int         e_lat, e_nb;
    logic [63:0] e_rd;
    logic [31:0] e_a0, e_a1;
    int          n;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_rdata", 64'(resp_rdata), 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    chk("rst_resp_cause", 64'(resp_cause), 64'd0);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    rst = 1'b0; mem_init = 1'b0;

    // loads from 0x100 = 0x8899AABB
    pb(32'h100, 4'b0000, 32'h0); issue(1'b0, 3'b011, 32'h102, 32'h0, 32'hFFFFFF99, 1'b0, 2'b00, 3, 1'b1);
    pb(32'h100, 4'b0000, 32'h0); issue(1'b0, 3'b100, 32'h102, 32'h0, 32'h00000099, 1'b0, 2'b00, 3, 1'b1);
    pb(32'h100, 4'b0000, 32'h0); issue(1'b0, 3'b001, 32'h102, 32'h0, 32'hFFFF8899, 1'b0, 2'b00, 3, 1'b1);
    pb(32'h100, 4'b0000, 32'h0); issue(1'b0, 3'b010, 32'h100, 32'h0, 32'h0000AABB, 1'b0, 2'b00, 3, 1'b1);
    // aligned halfword store, read back
    pb(32'h204, 4'b1100, 32'h12340000); issue(1'b1, 3'b001, 32'h206, 32'h00001234, 32'h0, 1'b0, 2'b00, 2, 1'b1);
    pb(32'h204, 4'b0000, 32'h0); issue(1'b0, 3'b001, 32'h206, 32'h0, 32'h00001234, 1'b0, 2'b00, 3, 1'b1);
    // split word store at 0x103, then split loads across 0x100/0x104
    pb(32'h100, 4'b1000, 32'hEF000000); pb(32'h104, 4'b0111, 32'h00DEADBE);
    issue(1'b1, 3'b000, 32'h103, 32'hDEADBEEF, 32'h0, 1'b0, 2'b00, 3, 1'b1);
    pb(32'h100, 4'b0000, 32'h0); pb(32'h104, 4'b0000, 32'h0);
    issue(1'b0, 3'b000, 32'h103, 32'h0, 32'hDEADBEEF, 1'b0, 2'b00, 4, 1'b1);
    pb(32'h100, 4'b0000, 32'h0); issue(1'b0, 3'b011, 32'h103, 32'h0, 32'hFFFFFFEF, 1'b0, 2'b00, 3, 1'b1);
    pb(32'h100, 4'b0000, 32'h0); pb(32'h104, 4'b0000, 32'h0);
    issue(1'b0, 3'b001, 32'h103, 32'h0, 32'hFFFFBEEF, 1'b0, 2'b00, 4, 1'b1);
    // illegal controls on a 32-bit memory: no beats
    issue(1'b0, 3'b101, 32'h100, 32'h0, 32'h0, 1'b1, 2'b10, 1, 1'b1);
    issue(1'b1, 3'b111, 32'h100, 32'h11111111, 32'h0, 1'b1, 2'b10, 1, 1'b1);
    issue(1'b0, 3'b110, 32'h104, 32'h0, 32'h0, 1'b1, 2'b10, 1, 1'b1);
    // byte store with junk in the upper bits, then whole word
    pb(32'h100, 4'b0010, 32'h00005A00); issue(1'b1, 3'b011, 32'h101, 32'hFFFFFF5A, 32'h0, 1'b0, 2'b00, 2, 1'b1);
    pb(32'h100, 4'b0000, 32'h0); issue(1'b0, 3'b000, 32'h100, 32'h0, 32'hEF995ABB, 1'b0, 2'b00, 3, 1'b1);
    drain();

    // reset during BEAT1 of a split load: no response, outputs back to reset values
    pb(32'h100, 4'b0000, 32'h0); pb(32'h104, 4'b0000, 32'h0);
    issue(1'b0, 3'b000, 32'h103, 32'h0, 32'h0, 1'b0, 2'b00, 0, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!(mem_en && mem_addr == 32'h104) && n < 10);
    chk("beat1_reached", 64'(mem_addr), 64'h104);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_req_ready", 64'(req_ready), 64'd1);
    chk("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("mid_rst_mem_en", 64'(mem_en), 64'd0);
    chk("mid_rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("mid_rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("mid_rst_resp_rdata", 64'(resp_rdata), 64'd0);
    repeat (4) @(negedge clk);
    chk("mid_rst_idle_after", 64'(req_ready), 64'd1);
    pb(32'h104, 4'b0000, 32'h0); issue(1'b0, 3'b000, 32'h104, 32'h0, 32'h00DEADBE, 1'b0, 2'b00, 3, 1'b1);
    drain();

    // SPLIT_EN=0: crossing load rejected without touching memory
    ns_run(1'b0, 3'b000, 32'h002, e_err, e_cause, e_lat);
    chk("ns_misalign_err", 64'(e_err), 64'd1);
    chk("ns_misalign_cause", 64'(e_cause), 64'd1);
    chk("ns_misalign_lat", 64'(e_lat), 64'd1);
    chk("ns_mem_en_seen", 64'(ns_en_seen), 64'd0);
    ns_run(1'b1, 3'b000, 32'h008, e_err, e_cause, e_lat);
    chk("ns_aligned_err", 64'(e_err), 64'd0);
    chk("ns_aligned_lat", 64'(e_lat), 64'd2);

    // DATA_W=64: doubleword wrapping past the top of the address space
    w_run(3'b101, 32'hFFFF_FFFC, e_rd, e_lat, e_nb, e_a0, e_a1);
    chk("w_beats", 64'(e_nb), 64'd2);
    chk("w_beat0_addr", 64'(e_a0), 64'hFFFF_FFF8);
    chk("w_beat1_addr", 64'(e_a1), 64'h0);
    chk("w_dword_rdata", e_rd, 64'h89ABCDEF01234567);
    chk("w_dword_lat", 64'(e_lat), 64'd4);
    w_run(3'b110, 32'h4, e_rd, e_lat, e_nb, e_a0, e_a1);
    chk("w_wordu_rdata", e_rd, 64'h0000000001234567);
    w_run(3'b000, 32'h0, e_rd, e_lat, e_nb, e_a0, e_a1);
    chk("w_word_rdata", e_rd, 64'hFFFFFFFF89ABCDEF);
    chk("w_word_lat", 64'(e_lat), 64'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dm_access_unit.md
# dm_access_unit

Parametrised, multi-cycle data-memory access unit between the CPU's MEM stage and a synchronous-read block RAM. It performs byte, halfword, word, and (when DATA_W=64) doubleword loads and stores with sign or zero extension. Accesses that cross a memory-word boundary are either split into two memory beats or rejected with a misalignment cause for the interrupt/exception logic. It replaces the single-cycle combinational data-memory controller.

## Interface
- DATA_W, 32: memory word width; 32 or 64 only.
- ADDR_W, 32: byte-address width.
- SPLIT_EN, 1: 1 means boundary-crossing accesses are split into two beats; 0 means they are rejected (cause MISALIGN).
- clk  in  1  system clock; every register is updated on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  access request from the pipeline.
- req_ready  out  1  high only in IDLE; an access is accepted when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-aligned.
- req_ctrl  in  3  access type:
  - 000 word; 001 halfword; 010 halfword unsigned; 011 byte; 100 byte unsigned.
  - 101 doubleword; 110 word unsigned. These two are legal only when DATA_W=64.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_W  extended load result; 0 for stores and errors.
- resp_err  out  1  access rejected; no memory write occurred.
- resp_cause  out  2  00 none, 01 MISALIGN, 10 BAD_CTRL.
- mem_en  out  1  memory beat strobe.
- mem_we  out  DATA_W/8  byte write enables.
- mem_addr  out  ADDR_W  word-aligned byte address.
- mem_wdata  out  DATA_W  lane-positioned store data.
- mem_rdata  in  DATA_W  read data; valid the cycle after mem_en.

## Operation
- States are IDLE, BEAT0, BEAT1, CAPT, RESP. Request fields are latched on accept.
- Definitions:
  - NB = DATA_W/8.
  - lane = addr mod NB.
  - size in bytes is 1, 2, 4 or 8.
  - split = lane + size > NB.
- IDLE, on accept:
  - illegal ctrl goes to RESP with BAD_CTRL;
  - split with SPLIT_EN=0 goes to RESP with MISALIGN;
  - otherwise goes to BEAT0.
- BEAT0:
  - mem_addr = addr with the low bits cleared.
  - mem_we = low NB bits of (((1<<size)-1) << lane) when storing, else 0.
  - mem_wdata = low DATA_W bits of (req_wdata << 8·lane).
  - Next state: BEAT1 if split; otherwise CAPT for a load, RESP for a store.
- BEAT1:
  - mem_addr = BEAT0 address + NB, modulo 2^ADDR_W (the top address wraps to 0).
  - Strobes and data are the upper NB bits / DATA_W bits of the same shifted values.
  - Load: capture the beat-0 mem_rdata, then go to CAPT. Store: go to RESP.
- CAPT:
  - Capture the last beat.
  - Result = ({beat1, beat0} >> 8·lane), truncated to size bytes.
  - Extend: sign-extend for signed types, zero-extend for unsigned types. Go to RESP.
- RESP: assert resp_valid with the registered rdata/err/cause, then go to IDLE.
- mem_en is high exactly in BEAT0 and BEAT1. mem_we is nonzero only for stores in those states.
- A request presented while not in IDLE is not accepted.

## Timing
- Latency, counted from the accept edge at cycle 0 to resp_valid:
  - error: cycle 1;
  - aligned store: cycle 2;
  - split store: cycle 3;
  - aligned load: cycle 3;
  - split load: cycle 4.
- The next accept is possible the cycle after RESP.
- All outputs are registered or state-decoded. No combinational path from req_* or mem_rdata to any output.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, resp_cause=00, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Reset mid-operation returns to IDLE the next cycle with no response.
  - A split store interrupted after BEAT0 leaves beat 0 written; there is no rollback.

## Structure
- Package dm_pkg holds:
  - the req_ctrl encodings (dm_word … dm_word_unsigned);
  - the cause codes;
  - the state enum;
  - a size-of-ctrl function.
- Sub-module dm_lane_align: combinational store shift/strobe generation and load shift/extract/extend, parametrised by DATA_W.
- The parent module holds the FSM and the registers.

## Test plan
- DATA_W=32, mem[0x100]=0x8899AABB, load byte at 0x102 → resp_rdata 0xFFFFFF99 at cycle 3. Byte unsigned → 0x00000099.
- Store halfword 0x1234 at 0x206 → one beat, mem_we=1100, mem_wdata=0x12340000, resp_valid at cycle 2.
- SPLIT_EN=1, store word 0xDEADBEEF at 0x103:
  - beat0 at 0x100: mem_we=1000, data byte3=0xEF;
  - beat1 at 0x104: mem_we=0111, bytes 0xBE, 0xAD, 0xDE;
  - resp at cycle 3.
  - Then load word from 0x103 → 0xDEADBEEF at cycle 4.
- SPLIT_EN=0, load word at 0x002 → resp_err=1, cause=01 at cycle 1, mem_en never high.
- DATA_W=32, req_ctrl=101 → cause=10. DATA_W=64, doubleword at 0xFFFF_FFFC with SPLIT_EN=1 → beat1 mem_addr=0x0000_0000.
- Assert rst during BEAT1 of a split load → next cycle IDLE, all outputs at reset values, no resp_valid.
